// File: rtl/cluster_root_parity_builder_if.sv
// cluster_root_parity_builder_if
// Groups the handshake and data signals of cluster_root_parity_builder.
// The geometry parameters must match the ones given to the builder.
//   go                     : start pulse (master -> slave)
//   defects                : per-PU syndrome defect flags (master -> slave)
//   boundary_flags         : per-PU boundary adjacency flags (master -> slave)
//   roots                  : per-PU linear root index, PU n at [ADDRESS_WIDTH*n +: ADDRESS_WIDTH]
//   is_odd_cardinalities   : per-root defect parity (slave -> master)
//   is_touching_boundaries : per-root boundary contact (slave -> master)
//   busy, done, root_error : status (slave -> master)
interface cluster_root_parity_builder_if #(
  parameter int CODE_DISTANCE_X = 4,
  parameter int CODE_DISTANCE_Z = 12
);
  localparam int MEASUREMENT_ROUNDS  = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z;
  localparam int PER_DIMENSION_WIDTH = $clog2(MEASUREMENT_ROUNDS);
  localparam int ADDRESS_WIDTH       = 3 * PER_DIMENSION_WIDTH;
  localparam int PU_COUNT            = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS;

  logic                              go;
  logic [PU_COUNT-1:0]               defects;
  logic [PU_COUNT-1:0]               boundary_flags;
  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots;
  logic [PU_COUNT-1:0]               is_odd_cardinalities;
  logic [PU_COUNT-1:0]               is_touching_boundaries;
  logic                              busy;
  logic                              done;
  logic                              root_error;

  modport master (
    output go, defects, boundary_flags, roots,
    input  is_odd_cardinalities, is_touching_boundaries, busy, done, root_error
  );

  modport slave (
    input  go, defects, boundary_flags, roots,
    output is_odd_cardinalities, is_touching_boundaries, busy, done, root_error
  );
endinterface

// File: rtl/cluster_root_parity_builder.sv
// cluster_root_parity_builder
// After union-find growth/merge, scans every PU once and builds two
// root-indexed vectors for the boundary-cardinality stage: the parity of the
// defects in each cluster and whether any PU of the cluster touches the
// boundary.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : cluster_root_parity_builder_if.slave (go, defects, boundary_flags,
//           roots in; is_odd_cardinalities, is_touching_boundaries, busy,
//           done, root_error out)
module cluster_root_parity_builder #(
  parameter int CODE_DISTANCE_X = 4,
  parameter int CODE_DISTANCE_Z = 12
) (
  input logic                          clk,
  input logic                          reset,
  cluster_root_parity_builder_if.slave bus
);
  localparam int MEASUREMENT_ROUNDS  = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z;
  localparam int PER_DIMENSION_WIDTH = $clog2(MEASUREMENT_ROUNDS);
  localparam int ADDRESS_WIDTH       = 3 * PER_DIMENSION_WIDTH;
  localparam int PU_COUNT            = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS;
  localparam int INDEX_WIDTH         = $clog2(PU_COUNT);

  localparam logic [INDEX_WIDTH-1:0]   LAST_INDEX = INDEX_WIDTH'(PU_COUNT - 1);
  // Roots are range-checked at the full address width.
  localparam logic [ADDRESS_WIDTH-1:0] ROOT_LIMIT = ADDRESS_WIDTH'(PU_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t                   state;
  logic [INDEX_WIDTH-1:0]   scan_idx;

  logic                     cap_valid;
  logic [ADDRESS_WIDTH-1:0] cap_root;
  logic                     cap_defect;
  logic                     cap_boundary;

  logic [ADDRESS_WIDTH-1:0] root_array [PU_COUNT];
  logic                     cap_root_ok;
  logic [INDEX_WIDTH-1:0]   cap_root_idx;

  // Unpack the flat root bus so the scan can select one entry with a
  // plain array index.
  for (genvar g = 0; g < PU_COUNT; g++) begin : g_root_unpack
    assign root_array[g] = bus.roots[ADDRESS_WIDTH*g +: ADDRESS_WIDTH];
  end

  // Once the root is known to be below PU_COUNT, its low bits are a valid
  // vector index.
  assign cap_root_ok  = (cap_root < ROOT_LIMIT);
  assign cap_root_idx = cap_root[INDEX_WIDTH-1:0];

  // Stage 1 captures one PU per cycle; stage 2 applies the capture made on
  // the previous edge. Stage 2 is the only writer of the vectors, so two
  // consecutive PUs with the same root accumulate without forwarding.
  // The go-time clear is placed after stage 2 so it always wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                      <= IDLE;
      scan_idx                   <= '0;
      cap_valid                  <= 1'b0;
      cap_root                   <= '0;
      cap_defect                 <= 1'b0;
      cap_boundary               <= 1'b0;
      bus.is_odd_cardinalities   <= '0;
      bus.is_touching_boundaries <= '0;
      bus.busy                   <= 1'b0;
      bus.done                   <= 1'b0;
      bus.root_error             <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      if (cap_valid) begin
        if (cap_root_ok) begin
          bus.is_odd_cardinalities[cap_root_idx]   <= bus.is_odd_cardinalities[cap_root_idx] ^ cap_defect;
          bus.is_touching_boundaries[cap_root_idx] <= bus.is_touching_boundaries[cap_root_idx] | cap_boundary;
        end else begin
          bus.root_error <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (bus.go) begin
            bus.is_odd_cardinalities   <= '0;
            bus.is_touching_boundaries <= '0;
            bus.root_error             <= 1'b0;
            scan_idx                   <= '0;
            bus.busy                   <= 1'b1;
            state                      <= SCAN;
          end
        end

        SCAN: begin
          cap_root     <= root_array[scan_idx];
          cap_defect   <= bus.defects[scan_idx];
          cap_boundary <= bus.boundary_flags[scan_idx];
          cap_valid    <= 1'b1;
          scan_idx     <= scan_idx + INDEX_WIDTH'(1);
          if (scan_idx == LAST_INDEX) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          cap_valid <= 1'b0;
          bus.done  <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cluster_root_parity_builder.sv
// tb_cluster_root_parity_builder
// Directed and randomized scans of cluster_root_parity_builder with the
// default geometry (576 PUs, 12-bit roots). Expected vectors come from a
// per-PU reference model of the cluster parity / boundary contact rules.
module tb_cluster_root_parity_builder;
  localparam int PU_COUNT      = 576;
  localparam int ADDRESS_WIDTH = 12;
  localparam int SCAN_LATENCY  = PU_COUNT + 1;
  localparam int BUSY_CYCLES   = PU_COUNT + 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cluster_root_parity_builder_if bus ();

  cluster_root_parity_builder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [PU_COUNT-1:0] stim_def;
  logic [PU_COUNT-1:0] stim_bf;
  int                  stim_root [PU_COUNT];

  logic [PU_COUNT-1:0] exp_odd;
  logic [PU_COUNT-1:0] exp_touch;
  logic                exp_err;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [PU_COUNT-1:0] observed,
                             input logic [PU_COUNT-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
    end
  endtask

  task automatic selfRoots();
    for (int n = 0; n < PU_COUNT; n++) stim_root[n] = n;
    stim_def = '0;
    stim_bf  = '0;
  endtask

  task automatic driveBus();
    for (int n = 0; n < PU_COUNT; n++) bus.roots[ADDRESS_WIDTH*n +: ADDRESS_WIDTH] = ADDRESS_WIDTH'(stim_root[n]);
    bus.defects        = stim_def;
    bus.boundary_flags = stim_bf;
  endtask

  // Reference: every PU contributes its defect to its root's parity and its
  // boundary flag to its root's contact; an out-of-range root only raises
  // the error.
  task automatic computeModel();
    exp_odd   = '0;
    exp_touch = '0;
    exp_err   = 1'b0;
    for (int n = 0; n < PU_COUNT; n++) begin
      if (stim_root[n] < PU_COUNT) begin
        exp_odd[stim_root[n]]   = exp_odd[stim_root[n]] ^ stim_def[n];
        exp_touch[stim_root[n]] = exp_touch[stim_root[n]] | stim_bf[n];
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic checkScanResults(input string tag);
    computeModel();
    checkOutput({tag, "_odd"},   bus.is_odd_cardinalities,   exp_odd);
    checkOutput({tag, "_touch"}, bus.is_touching_boundaries, exp_touch);
    checkOutput({tag, "_err"},   PU_COUNT'(bus.root_error),  PU_COUNT'(exp_err));
  endtask

  // Runs one full scan. Optionally pulses go in the middle of the scan; go
  // is always held during the done cycle to show that it is ignored there.
  task automatic applyStimulus(input string tag, input bit inject_go);
    int e;
    int busy_cycles;
    bit seen;
    driveBus();
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go      = 1'b0;
    e           = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (e <= 2000) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      bus.go = (inject_go && (e == 100));
      @(negedge clk);
      e++;
    end
    checkOutput({tag, "_done_seen"},    PU_COUNT'(seen),        PU_COUNT'(1));
    checkOutput({tag, "_done_latency"}, PU_COUNT'(e),           PU_COUNT'(SCAN_LATENCY));
    checkOutput({tag, "_busy_cycles"},  PU_COUNT'(busy_cycles), PU_COUNT'(BUSY_CYCLES));
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    checkOutput({tag, "_done_width"}, PU_COUNT'(bus.done), PU_COUNT'(0));
    checkOutput({tag, "_idle_busy"},  PU_COUNT'(bus.busy), PU_COUNT'(0));
    @(negedge clk);
    checkOutput({tag, "_go_in_done_ignored"}, PU_COUNT'(bus.busy), PU_COUNT'(0));
    checkScanResults(tag);
  endtask

  // Starts a scan, asserts reset at scan cycle 200 and checks the abort.
  task automatic abortScan();
    int done_count;
    driveBus();
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("abort_pre_odd0", PU_COUNT'(bus.is_odd_cardinalities[0]), PU_COUNT'(1));
    reset = 1'b0;
    #1;
    checkOutput("abort_odd",   bus.is_odd_cardinalities,   '0);
    checkOutput("abort_touch", bus.is_touching_boundaries, '0);
    checkOutput("abort_busy",  PU_COUNT'(bus.busy),        PU_COUNT'(0));
    checkOutput("abort_done",  PU_COUNT'(bus.done),        PU_COUNT'(0));
    checkOutput("abort_err",   PU_COUNT'(bus.root_error),  PU_COUNT'(0));
    @(negedge clk);
    reset      = 1'b1;
    done_count = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (bus.done) done_count++;
    end
    checkOutput("abort_no_done", PU_COUNT'(done_count), PU_COUNT'(0));
    checkOutput("abort_idle",    PU_COUNT'(bus.busy),   PU_COUNT'(0));
  endtask

  task automatic randomStimulus(input bit allow_bad);
    for (int n = 0; n < PU_COUNT; n++) begin
      if (allow_bad && ($urandom_range(0, 39) == 0))
        stim_root[n] = PU_COUNT + int'($urandom_range(0, 4095 - PU_COUNT));
      else if ($urandom_range(0, 1) == 0)
        stim_root[n] = n;
      else
        stim_root[n] = int'($urandom_range(0, PU_COUNT - 1));
      stim_def[n] = ($urandom_range(0, 2) == 0);
      stim_bf[n]  = ($urandom_range(0, 4) == 0);
    end
  endtask

  initial begin
    reset  = 1'b0;
    bus.go = 1'b0;
    selfRoots();
    driveBus();
    repeat (3) @(negedge clk);
    checkOutput("reset_odd",   bus.is_odd_cardinalities,   '0);
    checkOutput("reset_touch", bus.is_touching_boundaries, '0);
    checkOutput("reset_busy",  PU_COUNT'(bus.busy),        PU_COUNT'(0));
    checkOutput("reset_done",  PU_COUNT'(bus.done),        PU_COUNT'(0));
    checkOutput("reset_err",   PU_COUNT'(bus.root_error),  PU_COUNT'(0));
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] empty scan");
    selfRoots();
    applyStimulus("empty", 1'b0);
    checkOutput("empty_odd_zero", bus.is_odd_cardinalities, '0);

    $display("[TB] two defects sharing root 5");
    selfRoots();
    stim_def[5]   = 1'b1;
    stim_def[17]  = 1'b1;
    stim_root[17] = 5;
    applyStimulus("pair", 1'b0);
    checkOutput("pair_odd5", PU_COUNT'(bus.is_odd_cardinalities[5]), PU_COUNT'(0));

    $display("[TB] third defect on root 5");
    stim_def[40]  = 1'b1;
    stim_root[40] = 5;
    applyStimulus("triple", 1'b0);
    checkOutput("triple_odd5",  PU_COUNT'(bus.is_odd_cardinalities[5]), PU_COUNT'(1));
    checkOutput("triple_touch", bus.is_touching_boundaries,              '0);

    $display("[TB] back-to-back same root");
    selfRoots();
    for (int n = 100; n <= 102; n++) begin
      stim_def[n]  = 1'b1;
      stim_root[n] = 100;
    end
    applyStimulus("b2b", 1'b0);
    checkOutput("b2b_odd100", PU_COUNT'(bus.is_odd_cardinalities[100]), PU_COUNT'(1));

    $display("[TB] boundary flag on a non-root PU");
    selfRoots();
    stim_bf[30]   = 1'b1;
    stim_root[30] = 2;
    stim_def[2]   = 1'b1;
    applyStimulus("bnd", 1'b0);
    checkOutput("bnd_odd2",    PU_COUNT'(bus.is_odd_cardinalities[2]),    PU_COUNT'(1));
    checkOutput("bnd_touch2",  PU_COUNT'(bus.is_touching_boundaries[2]),  PU_COUNT'(1));
    checkOutput("bnd_touch30", PU_COUNT'(bus.is_touching_boundaries[30]), PU_COUNT'(0));

    $display("[TB] out-of-range root");
    selfRoots();
    stim_def[9]  = 1'b1;
    stim_root[9] = 4000;
    applyStimulus("bad", 1'b0);
    checkOutput("bad_err", PU_COUNT'(bus.root_error),  PU_COUNT'(1));
    checkOutput("bad_odd", bus.is_odd_cardinalities,   '0);
    selfRoots();
    applyStimulus("clear", 1'b0);
    checkOutput("clear_err", PU_COUNT'(bus.root_error), PU_COUNT'(0));

    $display("[TB] randomized scans");
    for (int r = 0; r < 4; r++) begin
      randomStimulus(r != 0);
      applyStimulus($sformatf("rand%0d", r), r[0]);
    end

    $display("[TB] reset mid-scan");
    selfRoots();
    stim_def[0] = 1'b1;
    stim_def[3] = 1'b1;
    stim_bf[4]  = 1'b1;
    abortScan();

    $display("[TB] scan after abort");
    randomStimulus(1'b0);
    applyStimulus("recover", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
